// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: selection-mode encodings
// and the rule for sizing channel-index fields from the channel count.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index; never narrower than one bit so a two-channel
  // mux still has a usable select field.
  function automatic int calc_selw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping
// around.
// The request vector is doubled so the wrap-around search becomes a
// single lowest-set-bit search above the pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 2,
  parameter int SELW = calc_selw(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // Build the doubled request vector and drop everything below ptr in the
  // lower copy, so the upper copy supplies the wrapped-around requesters
  always_comb begin
    req_dbl = {req, req};
    mask    = '0;
    for (int i = 0; i < 2 * N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req_dbl & mask;
  end

  // Lowest surviving bit wins; fold its position back into 0..N-1
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    gnt     = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        any_gnt = 1'b1;
        gnt_idx = SELW'(i % N);
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = any_gnt && (gnt_idx == SELW'(i));
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel, W-bit stream multiplexer with a registered output stage.
// Channel choice is either a fixed select or round-robin arbitration.
// in_ready is the only combinational output; data always goes through
// the output register.
module stream_mux_n
  import mux_pkg::*;
#(
  parameter int W    = 2,
  parameter int N    = 2,
  parameter int SELW = calc_selw(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_chan_q,  out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            load;
  logic [N-1:0]    arb_gnt;
  logic [SELW-1:0] arb_idx;
  logic            arb_any;
  logic            fix_any;
  logic [N-1:0]    fix_gnt;
  logic            grant_any;
  logic [SELW-1:0] grant_idx;
  logic [N-1:0]    grant_vec;
  logic [W-1:0]    grant_data;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  // Fixed-select path: an out-of-range sel matches no channel and so never
  // grants
  always_comb begin
    fix_any = 1'b0;
    fix_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        fix_any    = in_valid[i];
        fix_gnt[i] = in_valid[i];
      end
    end
  end

  // Pick the active grant source, steer the winning word, and raise
  // in_ready only when the output register can accept it
  always_comb begin
    load = ~out_valid_q | out_ready;
    if (mode == MODE_RR) begin
      grant_any = arb_any;
      grant_idx = arb_idx;
      grant_vec = arb_gnt;
    end else begin
      grant_any = fix_any;
      grant_idx = sel;
      grant_vec = fix_gnt;
    end
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
    in_ready = (load && !reset) ? grant_vec : '0;
  end

  // Next state of the output register and the round-robin pointer; a stall
  // leaves everything untouched
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_any) begin
        out_data_d  = grant_data;
        out_chan_d  = grant_idx;
        out_valid_d = 1'b1;
        if (mode == MODE_RR) begin
          ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset, which also discards any held word
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Randomised scoreboard bench for stream_mux_n with three channels of four bits.
// The model works out grants straight from the selection rules.
// Accepted words are queued and checked by a separate monitor when the
// DUT hands them downstream.
module tb_stream_mux_n;

  localparam int N    = 3;
  localparam int W    = 4;
  localparam int SELW = 2;

  typedef struct packed {
    logic [W-1:0]    data;
    logic [SELW-1:0] chan;
  } word_t;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            mode = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready = 1'b0;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];
  int    m_ptr  = 0;
  bit    m_full = 1'b0;

  stream_mux_n #(
    .W (W),
    .N (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  // After each edge, compare the registered outputs with the model
  task automatic checkOutput(input bit was_rst);
    checks++;
    if (out_valid !== m_full) begin
      errors++;
      $display("[TB] FAIL out_valid: got %0b expected %0b at %0t", out_valid, m_full, $time);
    end
    if (was_rst) begin
      checks++;
      if (out_data !== '0 || out_chan !== '0) begin
        errors++;
        $display("[TB] FAIL reset_regs: got data=%0h chan=%0d expected 0/0", out_data, out_chan);
      end
    end
  endtask

  // Drive one cycle, predict the grant from the rules, check in_ready, then
  // advance the model
  task automatic applyStimulus(input bit rst, input bit md, input logic [SELW-1:0] sl,
                               input logic [N-1:0] vld, input logic [N*W-1:0] dat,
                               input bit rdy);
    int g;
    bit ld;
    logic [N-1:0] exp_rdy;
    @(negedge clock);
    reset = rst; mode = md; sel = sl; in_valid = vld; in_data = dat; out_ready = rdy;
    #1;
    g = -1;
    if (!md) begin
      if (int'(sl) < N && ((vld >> sl) & 1) != 0) g = int'(sl);
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && ((vld >> c) & 1) != 0) g = c;
      end
    end
    ld = !m_full || rdy;
    exp_rdy = (g >= 0 && ld && !rst) ? N'(1 << g) : '0;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("[TB] FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    end
    if (rst) begin
      exp_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
    end else if (ld) begin
      if (g >= 0) begin
        word_t w;
        w.data = W'(dat >> (g * W));
        w.chan = SELW'(g);
        exp_q.push_back(w);
        m_full = 1'b1;
        if (md) m_ptr = (g + 1) % N;
      end else begin
        m_full = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    checkOutput(rst);
  endtask

  // Monitor: whenever a word leaves the DUT, it must be the oldest one expected
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got data=%0h chan=%0d expected none", out_data, out_chan);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          if (out_data !== e.data || out_chan !== e.chan) begin
            errors++;
            $display("[TB] FAIL word: got data=%0h chan=%0d expected data=%0h chan=%0d",
                     out_data, out_chan, e.data, e.chan);
          end
        end
      end
    end
  end

  initial begin
    // Reset
    applyStimulus(1, 1, 0, '0, '0, 0);
    applyStimulus(1, 1, 0, '0, '0, 0);

    // Round-robin rotation, channel i carries i
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 3'b111, {4'd2, 4'd1, 4'd0}, 1);

    // Backpressure after a capture
    applyStimulus(0, 1, 0, 3'b111, 12'(($urandom)), 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 3'b111, 12'(($urandom)), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 3'b111, 12'(($urandom)), 1);

    // Sparse requests from ptr=1: expect grants 2, 0, 2
    applyStimulus(1, 1, 0, '0, '0, 1);
    applyStimulus(0, 1, 0, 3'b001, 12'h5a7, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 3'b101, 12'(($urandom)), 1);

    // Fixed sel=0 with only channel 1 valid: no grant
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 3'b010, 12'(($urandom)), 1);

    // Out-of-range select, then resume round-robin from retained ptr
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3, 3'b111, 12'(($urandom)), 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 3, 3'b111, 12'(($urandom)), 1);

    // Reset while a word is held under backpressure
    applyStimulus(0, 1, 0, 3'b111, 12'(($urandom)), 1);
    applyStimulus(0, 1, 0, 3'b111, 12'(($urandom)), 0);
    applyStimulus(1, 1, 0, 3'b111, 12'(($urandom)), 0);
    applyStimulus(0, 1, 0, 3'b111, 12'h321, 1);
    applyStimulus(0, 1, 0, 3'b111, 12'h654, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom), SELW'($urandom_range(0, 3)),
                    N'($urandom), 12'(($urandom)), $urandom_range(0, 9) < 7);
    end

    // Drain and make sure nothing was lost
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, '0, '0, 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d words left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
